chameleon_usart_rx: RTL and testbench
=====================================

Name: chameleon_usart_rx

Overview:
- Receiver for the synchronous USART link from the Chameleon's on-board microcontroller.
- It is the counterpart to the transmit path that sends reconfigure/status frames to the microcontroller.
- Samples usart_tx (data) on rising edges of the microcontroller-driven usart_clk, deframes 8N1 characters, and buffers them in a small FIFO for the host/menu logic.
- Drives a CTS-style flow-control line so the microcontroller pauses before the FIFO overflows.

Parameters:
- FIFO_DEPTH, 4, number of buffered bytes; power of two, 2..16.
- CTS_MARGIN, 1, serial_cts_n goes high when fill >= FIFO_DEPTH - CTS_MARGIN.
- TIMEOUT_CYCLES, 65535, clk cycles without a serial_clk edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock (sysclk domain).
- reset  in  1  synchronous, active-high reset.
- serial_clk  in  1  USART clock from the microcontroller; asynchronous to clk.
- serial_rxd  in  1  USART data from the microcontroller; asynchronous to clk.
- serial_cts_n  out  1  0 = microcontroller may send, 1 = hold off.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- timeout  out  1  one-cycle pulse: partial frame abandoned.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high.
- Input synchronisation:
  - serial_clk and serial_rxd each pass through a 2-FF synchroniser (s1, s2), plus a prev register on clk.
  - edge = s2_clk & ~prev_clk. Data is taken from s2_rxd in the same cycle, so clock and data see equal latency.
- FSM (advances only on edge, except the timeout path):
  - IDLE: bit=0 -> DATA, bit counter 0. bit=1 -> stay.
  - DATA: shift bit into shift register LSB-first. After the 8th bit -> STOP.
  - STOP, bit=1: push the byte -> IDLE.
  - STOP, bit=0: frame_err pulse, byte discarded -> RESYNC.
  - RESYNC: wait for an edge with bit=1 -> IDLE. Prevents a continuous-0 line from being read as back-to-back start bits.
- Timeout:
  - A 16-bit counter clears on every edge and counts while state is DATA or STOP.
  - On reaching TIMEOUT_CYCLES: timeout pulse, return to IDLE, partial byte discarded.
  - Counter saturates; it never wraps.
- Latency: a rising serial_clk edge at the pin that samples a valid stop bit gives rx_valid=1 after exactly 3 rising clk edges, assuming the FIFO was previously empty.
- FIFO:
  - Circular buffer with read pointer, write pointer and count (log2(FIFO_DEPTH)+1 bits).
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data = mem[rd_ptr], combinational from registers. rx_valid = (count != 0).
- Push/pop rules:
  - Pop with rx_valid=0: ignored.
  - Push when full with no pop in the same cycle: byte dropped, overrun pulse, FIFO unchanged.
  - Push when full with a pop in the same cycle: both happen; count stays FIFO_DEPTH; no overrun.
  - Push and pop together when not full: count unchanged.
- Flow control: serial_cts_n is registered, = (count_next >= FIFO_DEPTH - CTS_MARGIN).
- Reset values:
  - State IDLE, counters 0, pointers 0, count 0.
  - rx_valid 0, rx_data 8'h00 (mem cleared), frame_err/overrun/timeout 0.
  - serial_cts_n 1 while reset is high, 0 on the first cycle after release.
  - Synchronisers reset to 1 (idle line, clock high), so no false edge on release.
- Reset mid-frame: partial byte and FIFO contents lost; no error pulse.
- Pulses are mutually exclusive by construction. frame_err and timeout never coincide with a push.

Decomposition:
- Shared package (chameleon_pkg): state enum {IDLE, DATA, STOP, RESYNC} and constant FRAME_BITS=8.
- One natural sub-module, chameleon_sync_fifo: parameterised depth/width, push/pop/full/empty/count. Reusable for the transmit side.
- Synchroniser and FSM stay in the top.

Test Plan:
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with serial_clk period 40 clk -> rx_valid rises 3 clk after the stop-bit edge; rx_data=0xA5; no pulses.
- Hold rx_ready=0, send 0x01,0x02,0x03,0x04,0x05:
  - serial_cts_n=1 after the 3rd byte.
  - 5th byte gives one overrun pulse.
  - Popping yields 0x01..0x04 in order, then rx_valid=0 and serial_cts_n=0.
- Frame 0x3C with stop bit 0, then line held 0 for 20 edges, then 1, then 0x7E -> one frame_err; no bytes from the 0-run; rx_data=0x7E.
- Stop serial_clk after 4 data bits, TIMEOUT_CYCLES=100 -> timeout pulse at cycle 100 after the last edge; FIFO empty; next full frame 0x55 is received correctly.
- FIFO full with rx_ready=1 on the exact cycle a new byte 0x99 completes -> no overrun; count stays 4; 0x99 is last out.
- Assert reset for 1 cycle mid-DATA with 2 bytes queued -> rx_valid=0 next cycle; serial_cts_n=1 during reset, 0 after; next frame 0xC3 is received.

Source files
------------

// File: rtl/chameleon_pkg.sv
// Shared constants for the Chameleon USART link.
// Receiver FSM encoding and frame geometry.
package chameleon_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_STOP   = 2'd2;
  localparam logic [1:0] ST_RESYNC = 2'd3;

  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/chameleon_sync_fifo.sv
// Small synchronous circular FIFO.
// A push into a full FIFO succeeds only alongside a pop.
module chameleon_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic          pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_next_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_q];
  assign count_next_o = count_d;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_d = count_q;
    if (push_ok & ~pop_ok)
      count_d = count_q + 1'b1;
    else if (pop_ok & ~push_ok)
      count_d = count_q - 1'b1;
  end

  // Storage, pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok)
        rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/chameleon_usart_rx.sv
// Synchronous 8N1 USART receiver from the microcontroller.
// Deframes on serial_clk rising edges into a FIFO with CTS.
module chameleon_usart_rx
  import chameleon_pkg::*;
#(
  parameter  int FIFO_DEPTH     = 4,
  parameter  int CTS_MARGIN     = 1,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int AW             = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_clk,
  input  logic       serial_rxd,
  output logic       serial_cts_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout
);

  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYCLES);
  localparam logic [AW:0] CTS_LVL  =
    (AW+1)'(FIFO_DEPTH - CTS_MARGIN);
  localparam logic [2:0]  LAST_BIT = 3'(FRAME_BITS - 1);

  logic s1_clk_q, s2_clk_q, prev_clk_q;
  logic s1_rxd_q, s2_rxd_q;
  logic sedge, sbit;

  logic [1:0]  state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] tmo_q, tmo_d;
  logic        push, fe_d, to_d, ov_d;
  logic        counting;

  logic        full, empty, pop;
  logic [AW:0] count_next;
  logic        cts_q, fe_q, ov_q, to_q;

  assign sedge = s2_clk_q & ~prev_clk_q;
  assign sbit  = s2_rxd_q;

  // Two-flop synchronisers; idle-high reset avoids a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_clk_q   <= 1'b1;
      s2_clk_q   <= 1'b1;
      prev_clk_q <= 1'b1;
      s1_rxd_q   <= 1'b1;
      s2_rxd_q   <= 1'b1;
    end else begin
      s1_clk_q   <= serial_clk;
      s2_clk_q   <= s1_clk_q;
      prev_clk_q <= s2_clk_q;
      s1_rxd_q   <= serial_rxd;
      s2_rxd_q   <= s1_rxd_q;
    end
  end

  assign counting = (state_q == ST_DATA) |
                    (state_q == ST_STOP);

  // Deframing FSM with saturating inter-edge timeout.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    fe_d     = 1'b0;
    to_d     = 1'b0;
    if (sedge)
      tmo_d = '0;
    else if (counting && tmo_q != 16'hFFFF)
      tmo_d = tmo_q + 16'd1;
    if (sedge) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!sbit) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {sbit, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == LAST_BIT)
            state_d = ST_STOP;
        end
        ST_STOP: begin
          if (sbit) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (sbit)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (counting &&
                 tmo_q >= TMO_LIM - 16'd1) begin
      to_d    = 1'b1;
      state_d = ST_IDLE;
    end
  end

  assign pop  = rx_ready & rx_valid;
  assign ov_d = push & full & ~pop;

  // FSM state, status pulses and registered flow control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tmo_q    <= '0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      to_q     <= 1'b0;
      cts_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tmo_q    <= tmo_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
      to_q     <= to_d;
      cts_q    <= (count_next >= CTS_LVL);
    end
  end

  chameleon_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .data_i       (shift_q),
    .pop_i        (pop),
    .data_o       (rx_data),
    .full_o       (full),
    .empty_o      (empty),
    .count_next_o (count_next)
  );

  assign rx_valid     = ~empty;
  assign serial_cts_n = cts_q;
  assign frame_err    = fe_q;
  assign overrun      = ov_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Directed bench for chameleon_usart_rx.
// Serial pins change on clk falling edges; outputs sampled away from rising edges.
module tb_chameleon_usart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_clk;
  logic       serial_rxd;
  logic       serial_cts_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int to_cnt   = 0;

  always #5 clk = ~clk;

  chameleon_usart_rx #(
    .FIFO_DEPTH     (4),
    .CTS_MARGIN     (1),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_clk   (serial_clk),
    .serial_rxd   (serial_rxd),
    .serial_cts_n (serial_cts_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
    if (timeout === 1'b1)   to_cnt++;
  end

  // Hold high half, drop clock with new data, hold low half, rise.
  // Returns on the falling clk edge where serial_clk rose.
  task automatic send_bit(input logic b);
    repeat (20) @(negedge clk);
    serial_clk = 1'b0;
    serial_rxd = b;
    repeat (20) @(negedge clk);
    serial_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic pop_expect(input string nm,
                            input logic [7:0] exp);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      failures++;
      $display("FAIL %s: valid=%b data=%h required valid=1 data=%h",
               nm, rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic expect_bit(input string nm,
                            input logic act,
                            input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic expect_int(input string nm,
                            input int act,
                            input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    serial_clk = 1'b1;
    serial_rxd = 1'b1;
    rx_ready   = 1'b0;
    repeat (3) @(negedge clk);
    expect_bit("rst_cts_hi", serial_cts_n, 1'b1);
    expect_bit("rst_valid", rx_valid, 1'b0);
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data: got %h required 00", rx_data);
    end
    reset = 1'b0;
    @(negedge clk);
    expect_bit("rst_cts_lo", serial_cts_n, 1'b0);
    repeat (10) @(negedge clk);
    expect_int("rst_pulses", fe_cnt + ov_cnt + to_cnt, 0);
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_bit("lat_before", rx_valid, 1'b0);
    @(posedge clk); #1;
    expect_bit("lat_at3", rx_valid, 1'b1);
    @(negedge clk);
    pop_expect("basic_a5", 8'hA5);
    expect_bit("basic_empty", rx_valid, 1'b0);
    expect_int("basic_pulses", fe_cnt + ov_cnt + to_cnt, 0);
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      repeat (6) @(negedge clk);
      if (i == 2)
        expect_bit("cts_after2", serial_cts_n, 1'b0);
      if (i == 3)
        expect_bit("cts_after3", serial_cts_n, 1'b1);
    end
    expect_int("ovr_pulse", ov_cnt - ov0, 1);
    for (int i = 1; i <= 4; i++)
      pop_expect("ovr_pop", 8'(i));
    expect_bit("ovr_empty", rx_valid, 1'b0);
    expect_bit("ovr_cts_lo", serial_cts_n, 1'b0);
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 20; i++)
      send_bit(1'b0);
    send_bit(1'b1);
    send_frame(8'h7E, 1'b1);
    repeat (6) @(negedge clk);
    expect_int("fe_pulse", fe_cnt - fe0, 1);
    pop_expect("fe_7e", 8'h7E);
    expect_bit("fe_empty", rx_valid, 1'b0);
  endtask

  task automatic test_timeout;
    int to0;
    to0 = to_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1);
    repeat (95) @(negedge clk);
    expect_int("tmo_early", to_cnt - to0, 0);
    repeat (15) @(negedge clk);
    expect_int("tmo_pulse", to_cnt - to0, 1);
    expect_bit("tmo_empty", rx_valid, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (6) @(negedge clk);
    pop_expect("tmo_55", 8'h55);
  endtask

  task automatic test_full_pop;
    int ov0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    repeat (6) @(negedge clk);
    ov0 = ov_cnt;
    send_frame(8'h99, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    expect_int("fp_no_ovr", ov_cnt - ov0, 0);
    expect_bit("fp_cts_full", serial_cts_n, 1'b1);
    pop_expect("fp_22", 8'h22);
    pop_expect("fp_33", 8'h33);
    pop_expect("fp_44", 8'h44);
    pop_expect("fp_99", 8'h99);
    expect_bit("fp_empty", rx_valid, 1'b0);
  endtask

  task automatic test_reset_mid;
    int p0;
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (6) @(negedge clk);
    p0 = fe_cnt + ov_cnt + to_cnt;
    reset = 1'b1;
    @(negedge clk);
    expect_bit("rm_valid", rx_valid, 1'b0);
    expect_bit("rm_cts_hi", serial_cts_n, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    expect_bit("rm_cts_lo", serial_cts_n, 1'b0);
    send_frame(8'hC3, 1'b1);
    repeat (6) @(negedge clk);
    pop_expect("rm_c3", 8'hC3);
    expect_bit("rm_empty", rx_valid, 1'b0);
    expect_int("rm_no_pulse", fe_cnt + ov_cnt + to_cnt, p0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_timeout();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
